// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers plus a fixed-latency mult/div
// whose result is computed at accept and committed when the down-counter expires.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [2:0]  mdOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 4;

  localparam logic [2:0] OpNone  = 3'b000;
  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;
  localparam logic [2:0] OpRsvd  = 3'b111;

  logic [CntW-1:0]  cnt;
  logic [CntW-1:0]  cntNext;
  logic [DataW-1:0] pendHi;
  logic [DataW-1:0] pendLo;
  logic             pendWrite;

  logic             accept;
  logic             commit;
  logic [2*DataW-1:0] prodS;
  logic [2*DataW-1:0] prodU;
  logic [DataW-1:0] divisorU;
  logic [DataW-1:0] absA;
  logic [DataW-1:0] absB;
  logic [DataW-1:0] magQ;
  logic [DataW-1:0] magR;
  logic [DataW-1:0] sQ;
  logic [DataW-1:0] sR;
  logic [DataW-1:0] uQ;
  logic [DataW-1:0] uR;

  // Accept qualification and counter next-state
  always_comb begin
    accept  = 1'b0;
    commit  = 1'b0;
    cntNext = cnt;
    if (start && !busy && (mdOp != OpNone) && (mdOp != OpRsvd)) begin
      accept = 1'b1;
    end
    if (accept && ((mdOp == OpMult) || (mdOp == OpMultu))) begin
      cntNext = CntW'(MULT_CYCLES);
    end else if (accept && ((mdOp == OpDiv) || (mdOp == OpDivu))) begin
      cntNext = CntW'(DIV_CYCLES);
    end else if (cnt != '0) begin
      cntNext = cnt - CntW'(1);
      commit  = (cnt == CntW'(1));
    end
  end

  // Arithmetic on the live operands; only latched into pending at accept.
  // Signed divide goes through magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    prodS    = {{DataW{srcA[DataW-1]}}, srcA} * {{DataW{srcB[DataW-1]}}, srcB};
    prodU    = {{DataW{1'b0}}, srcA} * {{DataW{1'b0}}, srcB};
    divisorU = (srcB == '0) ? DataW'(1) : srcB;
    absA     = srcA[DataW-1] ? (~srcA + DataW'(1)) : srcA;
    absB     = srcB[DataW-1] ? (~srcB + DataW'(1)) : divisorU;
    magQ     = absA / absB;
    magR     = absA % absB;
    sQ       = (srcA[DataW-1] ^ srcB[DataW-1]) ? (~magQ + DataW'(1)) : magQ;
    sR       = srcA[DataW-1] ? (~magR + DataW'(1)) : magR;
    uQ       = srcA / divisorU;
    uR       = srcA % divisorU;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      busy      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      pendHi    <= '0;
      pendLo    <= '0;
      pendWrite <= 1'b0;
    end else begin
      cnt  <= cntNext;
      busy <= (cntNext != '0);
      if (accept) begin
        unique case (mdOp)
          OpMult: begin
            {pendHi, pendLo} <= prodS;
            pendWrite        <= 1'b1;
          end
          OpMultu: begin
            {pendHi, pendLo} <= prodU;
            pendWrite        <= 1'b1;
          end
          OpDiv: begin
            pendHi    <= sR;
            pendLo    <= sQ;
            pendWrite <= (srcB != '0);
          end
          OpDivu: begin
            pendHi    <= uR;
            pendLo    <= uQ;
            pendWrite <= (srcB != '0);
          end
          OpMthi:  hi <= srcA;
          OpMtlo:  lo <= srcA;
          default: ;
        endcase
      end else if (commit && pendWrite) begin
        hi <= pendHi;
        lo <= pendLo;
      end
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu with hand-computed HI/LO results.
module tb_e_mdu;

  localparam logic [2:0] OpNone  = 3'b000;
  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  logic        clk;
  logic        reset;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [2:0]  mdOp;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int nCompared;
  int nMismatched;

  e_mdu dut (
    .clk   (clk),
    .reset (reset),
    .srcA  (srcA),
    .srcB  (srcB),
    .mdOp  (mdOp),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an op for one cycle at the current negedge; returns at the next negedge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdOp  = op;
    srcA  = a;
    srcB  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mdOp  = OpNone;
    srcA  = $urandom;
    srcB  = $urandom;
  endtask

  // Count busy cycles (starting at the current one) and check hold + commit values
  task automatic waitIdle(input string tag, input int already, input int expCycles,
                          input logic [31:0] oldHi, input logic [31:0] oldLo,
                          input logic [31:0] expHi, input logic [31:0] expLo);
    int  n;
    logic held;
    n    = already;
    held = 1'b1;
    while (busy && n < 40) begin
      if (hi !== oldHi || lo !== oldLo) held = 1'b0;
      n++;
      @(negedge clk);
    end
    checkEq({tag, "_cycles"}, 32'(n), 32'(expCycles));
    checkEq({tag, "_held"}, {31'd0, held}, 32'd1);
    checkEq({tag, "_hi"}, hi, expHi);
    checkEq({tag, "_lo"}, lo, expLo);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset = 1'b1;
    start = 1'b0;
    mdOp  = OpNone;
    srcA  = '0;
    srcB  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkEq("rst_busy", {31'd0, busy}, 32'd0);
    checkEq("rst_hi", hi, 32'h0);
    checkEq("rst_lo", lo, 32'h0);

    // signed mult -2 * 3
    issue(OpMult, 32'hFFFFFFFE, 32'd3);
    waitIdle("mult", 0, 5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);

    // back-to-back multu max * max
    issue(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitIdle("multu", 0, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFE, 32'h00000001);

    // div -7 / 2 with mtlo and mthi attempted while busy
    issue(OpDiv, 32'hFFFFFFF9, 32'd2);
    checkEq("div_busy1", {31'd0, busy}, 32'd1);
    issue(OpMtlo, 32'h5, 32'h0);
    issue(OpMthi, 32'h6, 32'h0);
    waitIdle("div", 2, 10, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD);

    // div 9 / -2 -> q -4, r 1
    issue(OpDiv, 32'd9, 32'hFFFFFFFE);
    waitIdle("divneg", 0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFC);

    // divu 100 / 7 -> q 14, r 2
    issue(OpDivu, 32'd100, 32'd7);
    waitIdle("divu", 0, 10, 32'h00000001, 32'hFFFFFFFC, 32'h2, 32'hE);

    // INT_MIN / -1 wraps
    issue(OpDiv, 32'h80000000, 32'hFFFFFFFF);
    waitIdle("divovf", 0, 10, 32'h2, 32'hE, 32'h0, 32'h80000000);

    // signed mult max positive squared
    issue(OpMult, 32'h7FFFFFFF, 32'h7FFFFFFF);
    waitIdle("multmax", 0, 5, 32'h0, 32'h80000000, 32'h3FFFFFFF, 32'h00000001);

    // mthi/mtlo then divide by zero keeps HI/LO
    issue(OpMthi, 32'h11, 32'h0);
    checkEq("mthi_hi", hi, 32'h11);
    checkEq("mthi_busy", {31'd0, busy}, 32'd0);
    issue(OpMtlo, 32'h22, 32'h0);
    checkEq("mtlo_lo", lo, 32'h22);
    issue(OpDivu, 32'd7, 32'd0);
    waitIdle("divz", 0, 10, 32'h11, 32'h22, 32'h11, 32'h22);

    // reset on third busy cycle of a mult aborts it
    issue(OpMult, 32'd4, 32'd5);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkEq("abort_busy", {31'd0, busy}, 32'd0);
    checkEq("abort_hi", hi, 32'h0);
    checkEq("abort_lo", lo, 32'h0);
    repeat (8) @(negedge clk);
    checkEq("abort_late_hi", hi, 32'h0);
    checkEq("abort_late_lo", lo, 32'h0);
    checkEq("abort_late_busy", {31'd0, busy}, 32'd0);

    // mthi immediately followed by mult 2 x 3
    issue(OpMthi, 32'hDEADBEEF, 32'h0);
    issue(OpMult, 32'd2, 32'd3);
    checkEq("mthi_mult_hi", hi, 32'hDEADBEEF);
    waitIdle("mthimult", 0, 5, 32'hDEADBEEF, 32'h0, 32'h0, 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003: srcA  input  32  operand A (rs value from E stage).
REQ-004: srcB  input  32  operand B (rt value from E stage).
REQ-005: mdOp  input  3  operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
REQ-006: start  input  1  qualifies mdOp for one cycle; ignored when mdOp is none or reserved.
REQ-007: busy  output  1  high while a mult/div is in flight.
REQ-008: hi  output  32  current HI register.
REQ-009: lo  output  32  current LO register.
REQ-010: Parameters: MULT_CYCLES, default 5, busy cycles for mult/multu; DIV_CYCLES, default 10, busy cycles for div/divu.

Function
REQ-011: Internal state: HI, LO (32 b each), pending HI/LO result registers, 4-bit down-counter cnt; busy SHALL be (cnt != 0), registered, with no combinational path from inputs.
REQ-012: Accept condition: start=1, busy=0, reset=0, and mdOp is a valid op.
REQ-013: On accepted mult: pending {HI,LO} = signed(srcA) x signed(srcB), 64 b; cnt loads MULT_CYCLES.
REQ-014: On accepted multu: unsigned 64-b product; cnt loads MULT_CYCLES.
REQ-015: On accepted div: LO = signed quotient truncated toward zero, HI = remainder with sign of srcA; cnt loads DIV_CYCLES.
REQ-016: On accepted divu: unsigned quotient to LO, unsigned remainder to HI; cnt loads DIV_CYCLES.
REQ-017: Divide by zero (srcB = 0): cnt still loads DIV_CYCLES and busy asserts normally; HI and LO SHALL be left unchanged at completion.
REQ-018: div with srcA = 0x80000000, srcB = 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wrap, no trap).
REQ-019: Operands SHALL be captured at the accept edge; later changes to srcA/srcB do not affect the result.
REQ-020: Timing: accept on edge N -> busy high during cycles N+1 .. N+k (k = MULT_CYCLES or DIV_CYCLES); on edge N+k cnt reaches 0, pending result is committed to HI/LO, and busy falls in the same cycle the new values appear on hi/lo.
REQ-021: mthi/mtlo accepted (busy=0): HI (resp. LO) = srcA at that edge, visible next cycle; busy stays 0.
REQ-022: start while busy=1 SHALL be ignored for every op, including mthi/mtlo; the in-flight result and cnt are unaffected.
REQ-023: A new op accepted on the first cycle busy=0 after completion SHALL proceed normally (back-to-back allowed).
REQ-024: hi/lo SHALL hold their previous values throughout a multi-cycle operation until the commit edge.
REQ-025: The pipeline stalls E-stage md instructions and mfhi/mflo externally while busy=1 or start=1; this block performs no stall or forwarding logic.

Reset
REQ-026: When reset=1 at a rising edge: HI=0, LO=0, cnt=0, busy=0, pending results=0; this has priority over start.
REQ-027: Reset during an operation SHALL abort it; no commit occurs and hi/lo read 0 from the following cycle.

Verification
REQ-028: After reset, mult with srcA=0xFFFFFFFE (-2), srcB=3, start=1 -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029: multu with srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-030: div with srcA=0xFFFFFFF9 (-7), srcB=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with srcA=7, srcB=0 after mthi 0x11 / mtlo 0x22 -> hi=0x11, lo=0x22 retained.
REQ-031: While div is busy, pulse start with mtlo, srcA=0x5 -> ignored; the final lo equals the div quotient only.
REQ-032: Assert reset on the 3rd busy cycle of a mult -> next cycle busy=0, hi=0, lo=0; no later commit.
REQ-033: mthi srcA=0xDEADBEEF followed next cycle by mult 2x3 -> hi=0xDEADBEEF during busy, then hi=0, lo=6.
